// File: rtl/audio_burst_packer_if.sv
// Stream bundle for audio_burst_packer: PCM samples in, burst samples and status out.
// The master side is the PCM source / burst sink; the slave side is the packer itself.
interface audio_burst_packer_if #(
   parameter int FIFO_DEPTH = 512
);
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic              pcm_valid;
   logic [15:0]       pcm_data;
   logic              audio_dv;
   logic [15:0]       audio_data;
   logic [FILL_W-1:0] fill_level;
   logic              overflow;
   logic [15:0]       frame_cnt;

   modport master (
      output pcm_valid, pcm_data,
      input  audio_dv, audio_data, fill_level, overflow, frame_cnt
   );

   modport slave (
      input  pcm_valid, pcm_data,
      output audio_dv, audio_data, fill_level, overflow, frame_cnt
   );
endinterface

// File: rtl/audio_burst_packer.sv
// Buffers PCM samples in a FIFO and releases them as fixed-length bursts of FRAME_LEN
// samples, separated by a forced idle gap, for the UDP audio sender.
module audio_burst_packer #(
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 512,
   parameter int GAP_CYCLES = 16
) (
   input  logic                 audio_clk,
   input  logic                 rstn,
   audio_burst_packer_if.slave  bus
);

   localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(FIFO_DEPTH);
   localparam logic [FILL_W-1:0] FRAME_LVL = FILL_W'(FRAME_LEN);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(FIFO_DEPTH - 1);
   localparam logic [ADDR_W-1:0] BEAT_LAST = ADDR_W'(FRAME_LEN - 1);
   localparam logic [15:0]       GAP_LAST  = 16'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      GAP
   } state_e;

   // Reset asserts immediately but releases only after two clean audio_clk edges.
   logic rst_meta_q;
   logic rst_sync_q;

   always_ff @(posedge audio_clk or negedge rstn) begin
      if (!rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   logic rst_int_n;
   assign rst_int_n = rst_sync_q;

   logic [15:0] mem [FIFO_DEPTH];
   logic [15:0] head_q;

   state_e            state_q,      state_d;
   logic [ADDR_W-1:0] beat_q,       beat_d;
   logic [15:0]       gap_q,        gap_d;
   logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q,     rd_ptr_d;
   logic [FILL_W-1:0] fill_q,       fill_d;
   logic              overflow_q,   overflow_d;
   logic [15:0]       frame_cnt_q,  frame_cnt_d;
   logic              rd_vld_q,     rd_vld_d;
   logic              audio_dv_q,   audio_dv_d;
   logic [15:0]       audio_data_q, audio_data_d;

   logic rd_en;
   logic wr_en;
   logic full;
   logic drop;

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      ptr_inc = (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
   endfunction

   // Sample storage: plain dual-port RAM with a registered read port, no reset.
   always_ff @(posedge audio_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.pcm_data;
      end
      if (rd_en) begin
         head_q <= mem[rd_ptr_q];
      end
   end

   // A read frees a slot in the same cycle, so a write at full is kept whenever a read happens.
   always_comb begin
      rd_en        = (state_q == BURST);
      full         = (fill_q == FULL_LVL);
      wr_en        = bus.pcm_valid && (!full || rd_en);
      drop         = bus.pcm_valid && full && !rd_en;

      wr_ptr_d     = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      fill_d       = fill_q;
      if (wr_en && !rd_en) begin
         fill_d = fill_q + FILL_W'(1);
      end else if (rd_en && !wr_en) begin
         fill_d = fill_q - FILL_W'(1);
      end

      overflow_d   = overflow_q | drop;
      rd_vld_d     = rd_en;
      audio_dv_d   = rd_vld_q;
      audio_data_d = rd_vld_q ? head_q : audio_data_q;

      state_d      = state_q;
      beat_d       = beat_q;
      gap_d        = gap_q;
      frame_cnt_d  = frame_cnt_q;

      // IDLE looks at the post-edge fill so a frame completing on this edge starts a burst now.
      case (state_q)
         IDLE: begin
            if (fill_d >= FRAME_LVL) begin
               state_d = BURST;
               beat_d  = '0;
            end
         end
         BURST: begin
            if (beat_q == BEAT_LAST) begin
               state_d     = GAP;
               gap_d       = '0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               beat_d = beat_q + ADDR_W'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge audio_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         gap_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         overflow_q   <= 1'b0;
         frame_cnt_q  <= '0;
         rd_vld_q     <= 1'b0;
         audio_dv_q   <= 1'b0;
         audio_data_q <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         gap_q        <= gap_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fill_q       <= fill_d;
         overflow_q   <= overflow_d;
         frame_cnt_q  <= frame_cnt_d;
         rd_vld_q     <= rd_vld_d;
         audio_dv_q   <= audio_dv_d;
         audio_data_q <= audio_data_d;
      end
   end

   assign bus.audio_dv   = audio_dv_q;
   assign bus.audio_data = audio_data_q;
   assign bus.fill_level = fill_q;
   assign bus.overflow   = overflow_q;
   assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_audio_burst_packer.sv
// Directed bench for audio_burst_packer: a small-frame instance for latency, streaming and
// mid-burst reset, and a depth-8 instance for full/overflow behaviour.
module tb_audio_burst_packer;

   logic audio_clk;
   logic rstn_a;
   logic rstn_b;

   int tests_run    = 0;
   int tests_failed = 0;

   audio_burst_packer_if #(.FIFO_DEPTH(64)) bus_a ();
   audio_burst_packer_if #(.FIFO_DEPTH(8))  bus_b ();

   audio_burst_packer #(
      .FRAME_LEN  (4),
      .FIFO_DEPTH (64),
      .GAP_CYCLES (2)
   ) dut_a (
      .audio_clk (audio_clk),
      .rstn      (rstn_a),
      .bus       (bus_a)
   );

   audio_burst_packer #(
      .FRAME_LEN  (8),
      .FIFO_DEPTH (8),
      .GAP_CYCLES (40)
   ) dut_b (
      .audio_clk (audio_clk),
      .rstn      (rstn_b),
      .bus       (bus_b)
   );

   initial begin
      audio_clk = 1'b0;
      forever #5 audio_clk = ~audio_clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected bench to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one DUT's PCM inputs for one cycle; returns just after the following falling edge.
   task automatic applyStimulus(input bit sel_b, input logic valid, input logic [15:0] data);
      if (sel_b) begin
         bus_b.pcm_valid = valid;
         bus_b.pcm_data  = data;
      end else begin
         bus_a.pcm_valid = valid;
         bus_a.pcm_data  = data;
      end
      @(posedge audio_clk);
      @(negedge audio_clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetA();
      checkOutput("a_rst_dv",    32'(bus_a.audio_dv),   32'd0);
      checkOutput("a_rst_data",  32'(bus_a.audio_data), 32'd0);
      checkOutput("a_rst_fill",  32'(bus_a.fill_level), 32'd0);
      checkOutput("a_rst_ovf",   32'(bus_a.overflow),   32'd0);
      checkOutput("a_rst_frame", 32'(bus_a.frame_cnt),  32'd0);
   endtask

   task automatic checkResetB();
      checkOutput("b_rst_dv",    32'(bus_b.audio_dv),   32'd0);
      checkOutput("b_rst_data",  32'(bus_b.audio_data), 32'd0);
      checkOutput("b_rst_fill",  32'(bus_b.fill_level), 32'd0);
      checkOutput("b_rst_ovf",   32'(bus_b.overflow),   32'd0);
      checkOutput("b_rst_frame", 32'(bus_b.frame_cnt),  32'd0);
   endtask

   // Hold reset across two edges, then give the internal synchroniser three edges to release.
   task automatic resetDut(input bit sel_b);
      if (sel_b) rstn_b = 1'b0;
      else       rstn_a = 1'b0;
      applyStimulus(sel_b, 1'b0, 16'h0);
      applyStimulus(sel_b, 1'b0, 16'h0);
      if (sel_b) checkResetB();
      else       checkResetA();
      if (sel_b) rstn_b = 1'b1;
      else       rstn_a = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(sel_b, 1'b0, 16'h0);
   endtask

   initial begin
      int          dv_seen;
      int          exp_next;
      int          high_run;
      int          low_run;
      logic        prev_dv;
      logic        seen;

      bus_a.pcm_valid = 1'b0;
      bus_a.pcm_data  = 16'h0;
      bus_b.pcm_valid = 1'b0;
      bus_b.pcm_data  = 16'h0;
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      #1;
      rstn_b = 1'b0;
      @(negedge audio_clk);

      // ---- Instance A: single frame 1..4, two-edge latency ----
      resetDut(1'b0);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 16'(i));
      checkOutput("a_fill_full_frame", 32'(bus_a.fill_level), 32'd4);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_dv_first_edge", 32'(bus_a.audio_dv), 32'd0);
      checkOutput("a_fill_after_read", 32'(bus_a.fill_level), 32'd3);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0);
         checkOutput("a_burst_dv", 32'(bus_a.audio_dv), 32'd1);
         checkOutput("a_burst_data", 32'(bus_a.audio_data), 32'(i));
      end
      checkOutput("a_frame_one", 32'(bus_a.frame_cnt), 32'd1);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_dv_after_burst", 32'(bus_a.audio_dv), 32'd0);
      checkOutput("a_data_hold", 32'(bus_a.audio_data), 32'd4);
      checkOutput("a_fill_empty", 32'(bus_a.fill_level), 32'd0);

      // ---- Instance A: reset on second beat of a burst ----
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 16'(i * 16));
      applyStimulus(1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_beat1_data", 32'(bus_a.audio_data), 32'h10);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_beat2_dv", 32'(bus_a.audio_dv), 32'd1);
      checkOutput("a_beat2_data", 32'(bus_a.audio_data), 32'h20);
      rstn_a = 1'b0;
      #1;
      checkResetA();
      @(negedge audio_clk);
      applyStimulus(1'b0, 1'b0, 16'h0);
      rstn_a = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0);
      for (int i = 5; i <= 7; i++) applyStimulus(1'b0, 1'b1, 16'(i));
      dv_seen = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0);
         if (bus_a.audio_dv) dv_seen++;
      end
      checkOutput("a_no_burst_three", 32'(dv_seen), 32'd0);
      checkOutput("a_fill_three", 32'(bus_a.fill_level), 32'd3);
      applyStimulus(1'b0, 1'b1, 16'd8);
      checkOutput("a_fill_four", 32'(bus_a.fill_level), 32'd4);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_post_rst_latency", 32'(bus_a.audio_dv), 32'd0);
      for (int i = 5; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0);
         checkOutput("a_post_rst_dv", 32'(bus_a.audio_dv), 32'd1);
         checkOutput("a_post_rst_data", 32'(bus_a.audio_data), 32'(i));
      end
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("a_post_rst_dv_low", 32'(bus_a.audio_dv), 32'd0);
      checkOutput("a_post_rst_frame", 32'(bus_a.frame_cnt), 32'd1);

      // ---- Instance A: 40 back-to-back samples, bursts of 4 with 3-cycle gaps ----
      resetDut(1'b0);
      exp_next = 1;
      high_run = 0;
      low_run  = 0;
      prev_dv  = 1'b0;
      seen     = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc < 40) applyStimulus(1'b0, 1'b1, 16'(cyc + 1));
         else          applyStimulus(1'b0, 1'b0, 16'h0);
         if (bus_a.audio_dv) begin
            if (!prev_dv && seen) checkOutput("cont_gap_len", 32'(low_run), 32'd3);
            checkOutput("cont_data", 32'(bus_a.audio_data), 32'(exp_next));
            exp_next++;
            high_run++;
            low_run = 0;
            seen    = 1'b1;
         end else begin
            if (prev_dv) begin
               checkOutput("cont_burst_len", 32'(high_run), 32'd4);
               high_run = 0;
            end
            low_run++;
         end
         prev_dv = bus_a.audio_dv;
      end
      checkOutput("cont_all_emitted", 32'(exp_next), 32'd41);
      checkOutput("cont_frames", 32'(bus_a.frame_cnt), 32'd10);
      checkOutput("cont_no_ovf", 32'(bus_a.overflow), 32'd0);
      checkOutput("cont_drained", 32'(bus_a.fill_level), 32'd0);

      // ---- Instance B: write at full during the first read is kept, no overflow ----
      resetDut(1'b1);
      for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b1, 16'(i));
      checkOutput("b_rdwr_full_fill", 32'(bus_b.fill_level), 32'd8);
      checkOutput("b_rdwr_full_ovf", 32'(bus_b.overflow), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         checkOutput("b_first_burst_data", 32'(bus_b.audio_data), 32'(i));
      end

      // ---- Instance B: overflow while in GAP, then read/write at full ----
      resetDut(1'b1);
      for (int i = 11; i <= 18; i++) applyStimulus(1'b1, 1'b1, 16'(i));
      checkOutput("b_fill_eight", 32'(bus_b.fill_level), 32'd8);
      for (int j = 1; j <= 9; j++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         if (j == 1) checkOutput("b_latency", 32'(bus_b.audio_dv), 32'd0);
         else        checkOutput("b_burst1_data", 32'(bus_b.audio_data), 32'(9 + j));
      end
      checkOutput("b_frame_one", 32'(bus_b.frame_cnt), 32'd1);
      checkOutput("b_empty_after_burst", 32'(bus_b.fill_level), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'h0);
      for (int i = 21; i <= 30; i++) begin
         applyStimulus(1'b1, 1'b1, 16'(i));
         if (i == 28) checkOutput("b_ovf_before_drop", 32'(bus_b.overflow), 32'd0);
      end
      checkOutput("b_fill_capped", 32'(bus_b.fill_level), 32'd8);
      checkOutput("b_ovf_set", 32'(bus_b.overflow), 32'd1);
      dv_seen = 0;
      for (int i = 0; i < 29; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         if (bus_b.audio_dv) dv_seen++;
      end
      checkOutput("b_gap_dv_low", 32'(dv_seen), 32'd0);
      applyStimulus(1'b1, 1'b1, 16'd31);
      checkOutput("b_rdwr_fill_same", 32'(bus_b.fill_level), 32'd8);
      checkOutput("b_rdwr_ovf_sticky", 32'(bus_b.overflow), 32'd1);
      for (int i = 21; i <= 28; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         checkOutput("b_burst2_dv", 32'(bus_b.audio_dv), 32'd1);
         checkOutput("b_burst2_data", 32'(bus_b.audio_data), 32'(i));
      end
      checkOutput("b_fill_one_left", 32'(bus_b.fill_level), 32'd1);
      checkOutput("b_frame_two", 32'(bus_b.frame_cnt), 32'd2);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("b_burst2_end", 32'(bus_b.audio_dv), 32'd0);
      for (int i = 32; i <= 38; i++) applyStimulus(1'b1, 1'b1, 16'(i));
      checkOutput("b_refill", 32'(bus_b.fill_level), 32'd8);
      dv_seen = 0;
      for (int i = 0; i < 33; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         if (bus_b.audio_dv) dv_seen++;
      end
      checkOutput("b_gap2_dv_low", 32'(dv_seen), 32'd0);
      for (int i = 31; i <= 38; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0);
         checkOutput("b_burst3_data", 32'(bus_b.audio_data), 32'(i));
      end
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("b_burst3_end", 32'(bus_b.audio_dv), 32'd0);
      checkOutput("b_frame_three", 32'(bus_b.frame_cnt), 32'd3);
      checkOutput("b_ovf_still_set", 32'(bus_b.overflow), 32'd1);
      checkOutput("b_final_fill", 32'(bus_b.fill_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
